// File: rtl/sccb_target.sv
// SCCB/I2C target: decodes device ID, sub-address and data bytes into register-bus strobes and serves reads.
// Optional SCCB_TARGET_GLITCH_FILT_EN adds a 3-sample stability filter on SCL/SDA.
module sccb_target #(
  parameter logic [6:0] DEV_ID         = 7'h21,
  parameter bit         ACK_EN_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_stb,
  output logic       reg_rd_stb,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WDATA, ACK_WR, RDATA, MACK, IGNORE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0] line_in, line_f, line_d_reg;
  assign line_in = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic sync1_reg, sync2_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= line_in[gi];
          sync2_reg <= sync1_reg;
        end
      end
`ifdef SCCB_TARGET_GLITCH_FILT_EN
      // The current sample plus two older ones must agree before the level moves.
      logic [1:0] hist_reg;
      logic       filt_reg, filt_level;
      assign filt_level = (hist_reg == {2{sync2_reg}}) ? sync2_reg : filt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_reg <= 2'b11;
          filt_reg <= 1'b1;
        end else begin
          hist_reg <= {hist_reg[0], sync2_reg};
          filt_reg <= filt_level;
        end
      end
      assign line_f[gi] = filt_level;
`else
      assign line_f[gi] = sync2_reg;
`endif
    end
  endgenerate

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = line_f[0];
  assign sda_f     = line_f[1];
  assign scl_rise  = scl_f & ~line_d_reg[0];
  assign scl_fall  = ~scl_f & line_d_reg[0];
  assign start_det = scl_f & line_d_reg[0] & line_d_reg[1] & ~sda_f;
  assign stop_det  = scl_f & line_d_reg[0] & ~line_d_reg[1] & sda_f;

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] tx_reg, tx_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       rw_reg, rw_next;
  logic       oe_reg, oe_next;
  logic       wr_stb_reg, wr_stb_next;
  logic       rd_stb_reg, rd_stb_next;
  logic       busy_reg, busy_next;
  logic       load_pend_reg, load_pend_next;
  logic [7:0] byte_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_d_reg    <= 2'b11;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rw_reg        <= 1'b0;
      oe_reg        <= 1'b0;
      wr_stb_reg    <= 1'b0;
      rd_stb_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      load_pend_reg <= 1'b0;
    end else begin
      line_d_reg    <= line_f;
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rw_reg        <= rw_next;
      oe_reg        <= oe_next;
      wr_stb_reg    <= wr_stb_next;
      rd_stb_reg    <= rd_stb_next;
      busy_reg      <= busy_next;
      load_pend_reg <= load_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    tx_next        = tx_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rw_next        = rw_reg;
    oe_next        = oe_reg;
    wr_stb_next    = 1'b0;
    rd_stb_next    = 1'b0;
    busy_next      = busy_reg;
    load_pend_next = rd_stb_reg;
    byte_in        = {shift_reg, sda_f};

    if (stop_det) begin
      state_next     = IDLE;
      oe_next        = 1'b0;
      busy_next      = 1'b0;
      load_pend_next = 1'b0;
    end else if (start_det) begin
      state_next     = DEVADDR;
      bit_cnt_next   = '0;
      oe_next        = 1'b0;
      load_pend_next = 1'b0;
    end else begin
      case (state_reg)
        DEVADDR, SUBADDR, WDATA: begin
          if (scl_rise) begin
            shift_next   = byte_in[6:0];
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              bit_cnt_next = '0;
              if (state_reg == DEVADDR) begin
                if (byte_in[7:1] == DEV_ID) begin
                  state_next = ACK_DEV;
                  busy_next  = 1'b1;
                  rw_next    = byte_in[0];
                end else begin
                  state_next = IGNORE;
                  busy_next  = 1'b0;
                end
              end else if (state_reg == SUBADDR) begin
                addr_next  = byte_in;
                state_next = ACK_SUB;
              end else begin
                wdata_next  = byte_in;
                wr_stb_next = 1'b1;
                state_next  = ACK_WR;
              end
            end
          end
        end
        // First fall drives ACK for the 9th clock, second fall ends it.
        ACK_DEV, ACK_SUB, ACK_WR: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd0) begin
              oe_next      = ACK_EN_DEFAULT;
              bit_cnt_next = 4'd1;
            end else begin
              oe_next      = 1'b0;
              bit_cnt_next = '0;
              if (state_reg == ACK_DEV) begin
                if (rw_reg) begin
                  rd_stb_next = 1'b1;
                  state_next  = RDATA;
                end else begin
                  state_next = SUBADDR;
                end
              end else if (state_reg == ACK_SUB) begin
                state_next = WDATA;
              end else begin
                addr_next  = addr_reg + 8'd1;
                state_next = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (load_pend_reg) begin
            oe_next = ~reg_rdata[7];
            tx_next = {reg_rdata[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              oe_next      = 1'b0;
              bit_cnt_next = '0;
              state_next   = MACK;
            end else begin
              oe_next = ~tx_reg[7];
              tx_next = {tx_reg[6:0], 1'b0};
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            addr_next = addr_reg + 8'd1;
            if (sda_f) state_next = IGNORE;
            else bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            rd_stb_next  = 1'b1;
            bit_cnt_next = '0;
            state_next   = RDATA;
          end
        end
        IGNORE:  oe_next = 1'b0;
        IDLE:    oe_next = 1'b0;
        default: state_next = IDLE;
      endcase
    end
  end

  assign sda_oe     = oe_reg;
  assign reg_addr   = addr_reg;
  assign reg_wdata  = wdata_reg;
  assign reg_wr_stb = wr_stb_reg;
  assign reg_rd_stb = rd_stb_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_sccb_target.sv
// Scoreboard bench for sccb_target: directed bus transactions, strobes checked by a monitor.
module tb_sccb_target;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, reg_wr_stb, reg_rd_stb, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h5C;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = sda_m & ~sda_oe;

  sccb_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_stb (reg_wr_stb),
    .reg_rd_stb (reg_rd_stb),
    .reg_rdata  (reg_rdata),
    .busy       (busy)
  );

  typedef struct {
    bit         is_rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe pops one expected transaction.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (rst_n && (reg_wr_stb || reg_rd_stb)) begin
      n_cmp++;
      if (reg_wr_stb && reg_rd_stb) begin
        n_err++;
        $display("FAIL strobe_overlap: both strobes high at addr %0h", reg_addr);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=%0h data=%0h, expected none",
                 reg_wr_stb, reg_rd_stb, reg_addr, reg_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_rd != reg_rd_stb || e.addr !== reg_addr || (!e.is_rd && e.data !== reg_wdata)) begin
          n_err++;
          $display("FAIL strobe: got rd=%0b addr=%0h data=%0h, expected rd=%0b addr=%0h data=%0h",
                   reg_rd_stb, reg_addr, reg_wdata, e.is_rd, e.addr, e.data);
        end else begin
          $display("txn %s addr=%02h data=%02h", e.is_rd ? "rd" : "wr", reg_addr,
                   e.is_rd ? reg_rdata : reg_wdata);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  // Entered with SCL low; leaves SCL low. seen = bus level mid high phase.
  task automatic clock_bit(input logic b, output logic seen);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); seen = sda_bus;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      v[i] = s;
    end
    clock_bit(nack, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] v;
    logic       s;

    tick(4);
    check("reset_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_addr", {24'b0, reg_addr}, 32'd0);
    rst_n = 1'b1;
    tick(4);

`ifdef SCCB_TARGET_GLITCH_FILT_EN
    sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(10);
    check("glitch_busy", {31'b0, busy}, 32'd0);
    scl_m = 1'b0;
    send_byte(8'h42, ack);
    check("glitch_no_ack", {31'b0, ack}, 32'd0);
    bus_stop();
`endif

    // Single write
    bus_start();
    send_byte(8'h42, ack); check("t1_ack_dev", {31'b0, ack}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h12, ack); check("t1_ack_sub", {31'b0, ack}, 32'd1);
    exp_q.push_back('{1'b0, 8'h12, 8'h80});
    send_byte(8'h80, ack); check("t1_ack_wr", {31'b0, ack}, 32'd1);
    bus_stop();
    check("t1_busy_after_stop", {31'b0, busy}, 32'd0);

    // Burst write with address wrap
    bus_start();
    send_byte(8'h42, ack); check("t2_ack_dev", {31'b0, ack}, 32'd1);
    send_byte(8'hFF, ack); check("t2_ack_sub", {31'b0, ack}, 32'd1);
    exp_q.push_back('{1'b0, 8'hFF, 8'h11});
    send_byte(8'h11, ack); check("t2_ack_wr0", {31'b0, ack}, 32'd1);
    exp_q.push_back('{1'b0, 8'h00, 8'h22});
    send_byte(8'h22, ack); check("t2_ack_wr1", {31'b0, ack}, 32'd1);
    bus_stop();
    check("t2_addr_after", {24'b0, reg_addr}, 32'h01);

    // Set sub-address, repeated START, read with NACK
    bus_start();
    send_byte(8'h42, ack); check("t3_ack_dev", {31'b0, ack}, 32'd1);
    send_byte(8'h0A, ack); check("t3_ack_sub", {31'b0, ack}, 32'd1);
    bus_start();
    exp_q.push_back('{1'b1, 8'h0A, 8'h00});
    send_byte(8'h43, ack); check("t3_ack_rd", {31'b0, ack}, 32'd1);
    read_byte(1'b1, v);
    check("t3_read_byte", {24'b0, v}, 32'h5C);
    bus_stop();
    check("t3_addr_after", {24'b0, reg_addr}, 32'h0B);
    check("t3_busy_after_stop", {31'b0, busy}, 32'd0);

    // Wrong device ID
    bus_start();
    oe_seen = 1'b0;
    send_byte(8'h60, ack); check("t4_nack_dev", {31'b0, ack}, 32'd0);
    send_byte(8'h12, ack); check("t4_nack_d0", {31'b0, ack}, 32'd0);
    send_byte(8'h34, ack); check("t4_nack_d1", {31'b0, ack}, 32'd0);
    bus_stop();
    check("t4_oe_never", {31'b0, oe_seen}, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd0);

    // Truncated data byte then STOP, then reset during a read
    bus_start();
    send_byte(8'h42, ack); check("t5_ack_dev", {31'b0, ack}, 32'd1);
    send_byte(8'h30, ack); check("t5_ack_sub", {31'b0, ack}, 32'd1);
    for (int i = 0; i < 5; i++) clock_bit(1'b1, s);
    bus_stop();
    bus_start();
    exp_q.push_back('{1'b1, 8'h30, 8'h00});
    send_byte(8'h43, ack); check("t5_ack_rd", {31'b0, ack}, 32'd1);
    clock_bit(1'b1, s); check("t5_rd_bit7", {31'b0, s}, 32'd0);
    clock_bit(1'b1, s); check("t5_rd_bit6", {31'b0, s}, 32'd1);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); check("t5_rd_bit5_driven", {31'b0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_addr", {24'b0, reg_addr}, 32'd0);
    check("t5_rst_wdata", {24'b0, reg_wdata}, 32'd0);
    check("t5_rst_strobes", {30'b0, reg_wr_stb, reg_rd_stb}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4 * Q);
    check("t5_idle_oe", {31'b0, sda_oe}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C target (responder) for the camera-configuration bus: the opposite end of the on-chip SCCB write master.
- Decodes START/STOP, device ID, sub-address and data bytes, and issues register-bus strobes for writes.
- Serves reads from a register bus.
- Used as an in-fabric camera-register shadow and as the bench responder for the configuration path.

Parameters:
- DEV_ID, 7'h21, 7-bit device address. Write byte 0x42, read byte 0x43.
- ACK_EN_DEFAULT, 1, 1 = drive ACK on matched bytes; 0 = leave 9th bit released (pure SCCB don't-care).

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL rate
- rst_n  in  1  asynchronous active-low reset
- scl_i  in  1  bus clock sampled from pad (async)
- sda_i  in  1  bus data sampled from pad (async)
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- reg_addr  out  8  current sub-address pointer
- reg_wdata  out  8  received data byte
- reg_wr_stb  out  1  one-clk write pulse
- reg_rd_stb  out  1  one-clk read-request pulse
- reg_rdata  in  8  read data; valid the clk after reg_rd_stb
- busy  out  1  high from matched START to STOP

Behaviour:
- Reset values (all outputs): sda_oe=0, reg_addr=0, reg_wdata=0, both strobes=0, busy=0. State = IDLE.
- Synchronisation: scl_i/sda_i pass through 2-FF synchronisers, then one history register.
- Edge and condition detection (on synchronised signals):
  - rise/fall = SCL edges.
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
- Sampling and driving: bits are shifted MSB first on SCL rise. sda_oe changes only on SCL fall (one clk after fall detect).
- States: IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WDATA, ACK_WR, RDATA, MACK, IGNORE.
- IDLE:
  - START → DEVADDR, bit counter = 0.
- DEVADDR:
  - After 8 bits, compare [7:1] with DEV_ID.
  - Match → ACK_DEV and busy=1.
  - Mismatch → IGNORE, with no ACK driven.
- ACK_DEV:
  - sda_oe=1 for the 9th clock (when ACK enabled).
  - R/W=0 → SUBADDR.
  - R/W=1 → reg_rd_stb pulses on the SCL fall ending ACK; MSB of reg_rdata is driven 2 clk later; → RDATA.
- SUBADDR:
  - 8 bits load reg_addr; → ACK_SUB → WDATA.
- WDATA:
  - 8 bits load reg_wdata.
  - reg_wr_stb pulses 1 clk after the 8th SCL rise, using the current reg_addr.
  - → ACK_WR. At the SCL fall ending ACK, reg_addr increments (8-bit wrap, 0xFF→0x00). → WDATA.
- RDATA:
  - Shift the latched byte out on SCL falls. A 0 bit drives sda_oe=1; a 1 bit releases.
  - After 8 bits, release SDA → MACK.
- MACK:
  - Sample SDA on SCL rise; reg_addr increments.
  - SDA=0 (ACK) → reg_rd_stb on next SCL fall, continue RDATA.
  - SDA=1 (NACK) → IGNORE until STOP/START.
- Any state: STOP → IDLE, sda_oe=0, busy=0. START (repeated) → DEVADDR; reg_addr is retained, so write-sub-address-then-read works.
- START and STOP take priority over bit shifting in the same clk.
- IGNORE: sda_oe held 0; only START/STOP are observed.
- Reset mid-transfer: immediate release of SDA and return to IDLE; an in-flight strobe is cancelled.
- Truncated byte followed by STOP: no reg_wr_stb is issued.
- Strobes: never asserted together. At most one per byte.

Optional Feature:
- Macro: SCCB_TARGET_GLITCH_FILT_EN.
- Defined:
  - A 3-sample stability filter follows the synchronisers. A level is accepted only after 3 equal consecutive samples.
  - Pulses shorter than 3 clk on SCL or SDA are rejected.
  - All detection latencies grow by 2 clk.
- Undefined:
  - No filter; the synchronised level is used directly.

Test Plan:
- Write 0x42, 0x12, 0x80 then STOP → three ACKs; reg_wr_stb once with reg_addr=0x12, reg_wdata=0x80; busy low after STOP.
- Burst write 0x42, 0xFF, 0x11, 0x22 → strobes at addr 0xFF (0x11), then 0x00 (0x22); wrap verified.
- Write 0x42, 0x0A, then repeated START, 0x43, reg_rdata=0x5C, master NACK → SDA bits 0,1,0,1,1,1,0,0; one reg_rd_stb; reg_addr=0x0B after.
- Wrong ID 0x60 followed by data bytes → sda_oe stays 0 throughout, no strobes, IDLE after STOP.
- STOP after 5 bits of data byte, then rst_n low during a read's 3rd bit → no wr strobe; SDA released within 1 clk of reset; all outputs at reset values.
- With SCCB_TARGET_GLITCH_FILT_EN: 1-clk low spike on SDA while SCL high → no START detected, state stays IDLE.
